// File: rtl/bus_reg_n.sv
// bus_reg_n: parametrised bus register for the 8-bit computer datapath.
// It loads from and drives the shared tristate bus. It can also increment,
// decrement, shift left or shift right its own value in place, and it keeps
// zero and carry flags. One block can therefore act as an A/B register,
// program counter, stack pointer or shift register.
//
// Optional feature macro: BUS_REG_N_SHADOW_EN
//   When defined, a WIDTH-bit shadow copy supports save/restore of q.
//   When undefined, no shadow storage exists and save/restore are ignored.
//
// Parameters:
//   WIDTH     register and bus width in bits (>= 2)
//   STEP      increment/decrement amount (1 <= STEP < 2^WIDTH)
//   RESET_VAL value loaded by clr
//
// Ports:
//   clk      rising-edge clock
//   clr      synchronous active-high reset
//   bus      shared tristate bus, driven with q while out=1
//   in       load q from bus at the clock edge
//   out      drive q onto bus (combinational)
//   op_en    perform op at the clock edge
//   op       00 inc, 01 dec, 10 shl, 11 shr
//   ser_in   bit shifted into the vacated position for shl/shr
//   save     copy q into shadow (shadow build only)
//   restore  copy shadow into q (shadow build only)
//   q        register contents
//   zf       q == 0
//   cf       carry/borrow/shifted-out bit of the last op
module bus_reg_n #(
  parameter int                 WIDTH     = 8,
  parameter int                 STEP      = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire [WIDTH-1:0]  bus,
  input  logic             in,
  input  logic             out,
  input  logic             op_en,
  input  logic [1:0]       op,
  input  logic             ser_in,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] q,
  output logic             zf,
  output logic             cf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] val_q, val_d;
  logic             cf_q, cf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_val;
  logic             op_cf;

  logic             restore_en;
  logic [WIDTH-1:0] shadow_val;

`ifdef BUS_REG_N_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;

  // save samples the pre-edge q, so save+restore on one edge swaps the two.
  always_comb begin
    shadow_d = shadow_q;
    if (save) shadow_d = val_q;
  end

  always_ff @(posedge clk) begin
    if (clr) shadow_q <= RESET_VAL;
    else     shadow_q <= shadow_d;
  end

  assign restore_en = restore;
  assign shadow_val = shadow_q;
`else
  logic unused_shadow_ports;
  assign unused_shadow_ports = ^{save, restore};
  assign restore_en = 1'b0;
  assign shadow_val = '0;
`endif

  // Result of the selected in-place op. The extra sum bit is the inc carry.
  always_comb begin
    sum    = {1'b0, val_q} + {1'b0, STEP_W};
    op_val = val_q;
    op_cf  = 1'b0;
    case (op)
      2'b00: begin
        op_val = sum[WIDTH-1:0];
        op_cf  = sum[WIDTH];
      end
      2'b01: begin
        op_val = val_q - STEP_W;
        op_cf  = (val_q < STEP_W);
      end
      2'b10: begin
        op_val = {val_q[WIDTH-2:0], ser_in};
        op_cf  = val_q[WIDTH-1];
      end
      default: begin
        op_val = {ser_in, val_q[WIDTH-1:1]};
        op_cf  = val_q[0];
      end
    endcase
  end

  // Priority below clr: restore > load > op > hold.
  always_comb begin
    val_d = val_q;
    cf_d  = cf_q;
    if (restore_en) begin
      val_d = shadow_val;
      cf_d  = 1'b0;
    end else if (in) begin
      val_d = bus;
      cf_d  = 1'b0;
    end else if (op_en) begin
      val_d = op_val;
      cf_d  = op_cf;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      val_q <= RESET_VAL;
      cf_q  <= 1'b0;
    end else begin
      val_q <= val_d;
      cf_q  <= cf_d;
    end
  end

  assign bus = out ? val_q : 'z;
  assign q   = val_q;
  assign zf  = (val_q == '0);
  assign cf  = cf_q;

endmodule

// File: doc/bus_reg_n.md
# bus_reg_n

Parametrised bus register for the 8-bit computer datapath, successor to the fixed 8-bit bus register. It loads from and drives the shared tristate bus and adds in-place arithmetic and shift operations (increment, decrement, shift left, shift right) with zero and carry flags. This lets one block serve as A/B register, program counter, stack pointer or shift register. An optional shadow copy supports save/restore of the value, e.g. around interrupts.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits (≥2)
- STEP, 1, increment/decrement amount (1 ≤ STEP < 2^WIDTH)
- RESET_VAL, 0, value loaded by clr

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  reset; synchronous, active-high
- bus  inout  WIDTH  shared system bus; tristate
- in  input  1  load register from bus at clock edge
- out  input  1  drive register value onto bus
- op_en  input  1  perform op at clock edge
- op  input  2  00 inc, 01 dec, 10 shl, 11 shr
- ser_in  input  1  bit shifted into the vacated position for shl/shr
- save  input  1  copy q into shadow (only with BUS_REG_N_SHADOW_EN)
- restore  input  1  copy shadow into q (only with BUS_REG_N_SHADOW_EN)
- q  output  WIDTH  register contents
- zf  output  1  q == 0
- cf  output  1  carry/borrow/shifted-out bit of the last op

## Operation
- Bus: out=1 drives bus = q; out=0 leaves bus high-impedance. Purely combinational, with no clock involvement.
- At each rising clk edge, the first matching row in this priority list applies:
  1. clr=1: q ← RESET_VAL, cf ← 0, shadow ← RESET_VAL.
  2. restore=1 (macro on): q ← shadow, cf ← 0.
  3. in=1: q ← bus, cf ← 0. With in=1 and out=1 together, q reloads its own value (no change) and cf clears.
  4. op_en=1: apply op as below.
  5. Otherwise: hold q and cf.
- Operations; all arithmetic is modulo 2^WIDTH:
  - inc: q ← q+STEP; cf ← 1 if the sum overflows WIDTH bits, else 0.
  - dec: q ← q−STEP; cf ← 1 if q<STEP (borrow), else 0.
  - shl: q ← {q[WIDTH-2:0], ser_in}; cf ← old q[WIDTH-1].
  - shr: q ← {ser_in, q[WIDTH-1:1]}; cf ← old q[0].
- save (macro on) is independent of the priority list. On an edge with save=1, shadow ← q as it was before that edge, unless clr is also high.
- save=1 with restore=1 on the same edge: q ← old shadow and shadow ← old q (swap).
- zf is combinational from q. cf is a register bit.

## Timing
- Reset values: q=RESET_VAL, cf=0, zf=(RESET_VAL==0), shadow=RESET_VAL, bus=Z while out=0.
- Load, op and restore latency: 1 cycle. The new q is visible after the edge and is driven onto the bus in the same cycle if out=1.
- Bus drive latency: 0 cycles from out, combinational.
- clr asserted mid-sequence overrides any in/op/restore on that edge. No partial update is allowed.
- An op is not a multi-cycle operation. Holding op_en=1 repeats the op every cycle (free-running counter or shifter).
- Wrap-around examples at WIDTH=8, STEP=1: inc of 0xFF gives 0x00 with cf=1; dec of 0x00 gives 0xFF with cf=1.

## Configuration
- BUS_REG_N_SHADOW_EN defined:
  - Shadow register of WIDTH bits is present.
  - save and restore behave as in Operation.
- Not defined:
  - No shadow storage is synthesised.
  - save and restore ports still exist but are ignored.
  - Priority reduces to clr > in > op_en > hold.

## Test plan
- clr=1 for one edge with RESET_VAL=0x00, then out=1 → q=0x00, zf=1, cf=0, bus=0x00. With out=0, bus=Z.
- Bus driven externally to 0xA5 with in=1 for one edge → q=0xA5. Then out=1, in=0 → bus reads 0xA5.
- q=0xFE, op=inc, op_en=1 for 3 edges → q=0xFF/cf=0, then 0x00/cf=1 with zf=1, then 0x01/cf=0.
- q=0x81, op=shl, ser_in=0 → q=0x02, cf=1. Then op=shr, ser_in=1 → q=0x81, cf=0.
- in=1 and op_en=1 on the same edge with bus=0x3C → q=0x3C, cf=0 (load wins). clr=1 together with in=1 and bus=0x3C → q=RESET_VAL.
- Macro on: q=0x12, save=1 → shadow=0x12. Load 0x34, then save=1 with restore=1 → q=0x12, shadow=0x34. Macro off: same stimulus → q stays 0x34.
